// File: rtl/mole_pkg.sv
// mole_pkg: shared types, constants and target picker for the whack-a-mole controller
package mole_pkg;

    typedef enum logic [2:0] {IDLE, GAP, SHOW, FLASH, OVER} state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [3:0] POS_NONE  = 4'd0;
    localparam logic [3:0] POS_MAX   = 4'd9;

    // map the LFSR onto 1..9, bumping past the previous target so it never repeats
    function automatic logic [3:0] pick_target(input logic [7:0] lfsr, input logic [3:0] prev);
        logic [3:0] cand;
        cand = 4'(lfsr % 8'd9) + 4'd1;
        return (cand == prev) ? ((cand == POS_MAX) ? 4'd1 : cand + 4'd1) : cand;
    endfunction

endpackage

// File: rtl/mole_game_ctrl_if.sv
// mole_game_ctrl_if: keypad/control inputs and display/score outputs of the game controller
interface mole_game_ctrl_if;

    logic       start;
    logic       pause;
    logic       key_valid;
    logic [3:0] key_code;
    logic       inGame;
    logic       stop;
    logic       hit;
    logic [3:0] position;
    logic [7:0] score;
    logic [7:0] misses;
    logic       game_over;

    modport master (
        output start, pause, key_valid, key_code,
        input  inGame, stop, hit, position, score, misses, game_over
    );

    modport slave (
        input  start, pause, key_valid, key_code,
        output inGame, stop, hit, position, score, misses, game_over
    );

endinterface

// File: rtl/ms_timer.sv
// ms_timer: clk prescaler to a millisecond tick plus a ms counter that flags reaching its limit
module ms_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] limit,
    output logic        expired
);

    localparam int PW = $clog2(TICK_DIV + 1);

    logic [PW-1:0] pre;
    logic [15:0]   ms;
    logic          tick;

    assign tick    = en && pre == PW'(TICK_DIV - 1);
    assign expired = tick && ms + 16'd1 == limit;

    // prescaler and ms count restart on clr and hold while disabled
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre <= '0;
            ms  <= '0;
        end else if (en) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) ms <= ms + 16'd1;
        end
    end

endmodule

// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: sequences whack-a-mole rounds, picks targets, judges presses and keeps score
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int         TICK_DIV = 50000,
    parameter int         SHOW_MS  = 800,
    parameter int         FLASH_MS = 200,
    parameter int         GAP_MS   = 300,
    parameter int         ROUNDS   = 20,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input logic             clk,
    input logic             rst,
    mole_game_ctrl_if.slave bus
);

    state_t      state, state_n;
    logic [7:0]  lfsr, round, round_n, score, score_n, misses, misses_n;
    logic [3:0]  target, target_n, position, position_n;
    logic        in_game, in_game_n, stop, stop_n, hit, hit_n, game_over, game_over_n;
    logic        frozen, expired, hit_key, starting, clr;
    logic [15:0] limit;

    assign frozen   = bus.pause && state inside {GAP, SHOW, FLASH};
    assign hit_key  = !frozen && state == SHOW && bus.key_valid && bus.key_code == target;
    assign starting = (state == IDLE || state == OVER) && state_n == GAP;
    assign clr      = state_n != state;
    assign limit    = state == GAP   ? 16'(GAP_MS)   :
                      state == SHOW  ? 16'(SHOW_MS)  :
                      state == FLASH ? 16'(FLASH_MS) : 16'd0;

    ms_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (!bus.pause),
        .limit  (limit),
        .expired(expired)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state: a paused game holds its state; start is only heard outside a game
    always_comb begin
        state_n = state;
        if (!frozen) begin
            case (state)
                IDLE, OVER: if (bus.start) state_n = GAP;
                GAP:        if (expired) state_n = SHOW;
                SHOW:       if (hit_key || expired) state_n = FLASH;
                FLASH:      if (expired) state_n = (round + 8'd1 == 8'(ROUNDS)) ? OVER : GAP;
                default:    state_n = IDLE;
            endcase
        end
    end

    // output/datapath next values, computed from the transition about to be taken
    always_comb begin
        target_n    = (state == GAP && state_n == SHOW) ? pick_target(lfsr, target) : target;
        round_n     = starting ? 8'd0 : (state == FLASH && state_n != FLASH) ? round + 8'd1 : round;
        score_n     = starting ? 8'd0 : (hit_key && score != 8'hFF) ? score + 8'd1 : score;
        misses_n    = starting ? 8'd0 :
                      (state == SHOW && state_n == FLASH && !hit_key && misses != 8'hFF) ? misses + 8'd1 : misses;
        in_game_n   = state_n inside {GAP, SHOW, FLASH};
        hit_n       = state_n == FLASH && (state == FLASH ? hit : hit_key);
        position_n  = (state_n == SHOW || state_n == FLASH) ? target_n : POS_NONE;
        stop_n      = bus.pause && in_game_n;
        game_over_n = state_n == OVER;
    end

    // LFSR free-runs every cycle outside reset
    always_ff @(posedge clk) begin
        if (rst) lfsr <= SEED;
        else     lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end

    // registered outputs and game counters
    always_ff @(posedge clk) begin
        if (rst) begin
            target    <= POS_NONE;
            round     <= '0;
            score     <= '0;
            misses    <= '0;
            in_game   <= 1'b0;
            hit       <= 1'b0;
            position  <= POS_NONE;
            stop      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            target    <= target_n;
            round     <= round_n;
            score     <= score_n;
            misses    <= misses_n;
            in_game   <= in_game_n;
            hit       <= hit_n;
            position  <= position_n;
            stop      <= stop_n;
            game_over <= game_over_n;
        end
    end

    assign bus.inGame    = in_game;
    assign bus.stop      = stop;
    assign bus.hit       = hit;
    assign bus.position  = position;
    assign bus.score     = score;
    assign bus.misses    = misses;
    assign bus.game_over = game_over;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl: directed self-checking bench for the whack-a-mole controller
module tb_mole_game_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_t = 0;
    int   exp_prev = 0;
    int   exp_score = 0;
    int   exp_miss = 0;
    int   rounds = 0;
    int   r = 0;
    logic [7:0] m, m_old;

    mole_game_ctrl_if ifc ();

    mole_game_ctrl #(
        .TICK_DIV(4), .SHOW_MS(5), .FLASH_MS(2), .GAP_MS(3), .ROUNDS(3), .SEED(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // reference LFSR, one cycle of history kept for the target pick
    always @(posedge clk) begin
        if (rst) m <= 8'hA5;
        else     m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
        m_old <= m;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input int l, input int prev);
        int c;
        c = l % 9 + 1;
        if (c == prev) c = (c == 9) ? 1 : c + 1;
        return c;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ingame"}, ifc.inGame, 0);
        chk({tag, "_stop"}, ifc.stop, 0);
        chk({tag, "_hit"}, ifc.hit, 0);
        chk({tag, "_pos"}, ifc.position, 0);
        chk({tag, "_score"}, ifc.score, 0);
        chk({tag, "_misses"}, ifc.misses, 0);
        chk({tag, "_over"}, ifc.game_over, 0);
    endtask

    task automatic gap_phase(input bit poke_start);
        int z = 0;
        while (ifc.position == 0 && z < 40) begin
            ifc.start = poke_start && z == 5;
            @(negedge clk);
            z++;
        end
        ifc.start = 1'b0;
        exp_t = pick(int'(m_old), exp_prev);
        chk("gap_len", z, 12);
        chk("target", ifc.position, exp_t);
        chk("pos_range", ifc.position >= 1 && ifc.position <= 9, 1);
        chk("no_repeat", ifc.position != 4'(exp_prev), 1);
        exp_prev = exp_t;
    endtask

    task automatic flash_phase(input bit h);
        int f = 0;
        int ok = 0;
        while (ifc.position != 0 && f < 40) begin
            ok += int'(ifc.position == 4'(exp_t) && ifc.hit == h);
            @(negedge clk);
            f++;
        end
        chk("flash_len", f, 8);
        chk("flash_hold", ok, 8);
        chk("post_flash_hit", ifc.hit, 0);
    endtask

    task automatic play_round(input int press_at, input int wrong_at);
        int c = 0;
        while (!ifc.hit && ifc.misses == 8'(exp_miss) && c < 60) begin
            ifc.key_valid = (c == press_at) || (c == wrong_at);
            ifc.key_code  = (c == wrong_at) ? 4'(exp_t % 9 + 1) : 4'(exp_t);
            @(negedge clk);
            c++;
        end
        ifc.key_valid = 1'b0;
        if (press_at >= 0) begin
            exp_score++;
            chk("hit_delay", c, press_at + 1);
            chk("hit", ifc.hit, 1);
        end else begin
            exp_miss++;
            chk("show_len", c, 20);
            chk("miss_hit", ifc.hit, 0);
        end
        chk("score", ifc.score, exp_score);
        chk("misses", ifc.misses, exp_miss);
        flash_phase(press_at >= 0);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.pause = 1'b0;
        ifc.key_valid = 1'b0;
        ifc.key_code = 4'd0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        exp_score = 0;
        exp_miss = 0;
        chk("start_ingame", ifc.inGame, 1);
        chk("start_pos", ifc.position, 0);
        gap_phase(1'b0);
        play_round(0, -1);
        gap_phase(1'b0);
        play_round(-1, 6);

        gap_phase(1'b0);
        repeat (7) @(negedge clk);
        ifc.pause = 1'b1;
        @(negedge clk);
        chk("pause_stop", ifc.stop, 1);
        for (int i = 0; i < 49; i++) begin
            ifc.key_valid = (i == 10);
            ifc.key_code  = 4'(exp_t);
            @(negedge clk);
        end
        ifc.key_valid = 1'b0;
        chk("pause_pos", ifc.position, exp_t);
        chk("pause_hit", ifc.hit, 0);
        chk("pause_score", ifc.score, exp_score);
        chk("pause_stop_hold", ifc.stop, 1);
        ifc.pause = 1'b0;
        r = 0;
        while (ifc.misses == 8'(exp_miss) && r < 40) begin
            @(negedge clk);
            r++;
        end
        exp_miss++;
        chk("show_remainder", r, 13);
        chk("resume_stop", ifc.stop, 0);
        chk("resume_misses", ifc.misses, exp_miss);
        flash_phase(1'b0);

        chk("over_flag", ifc.game_over, 1);
        chk("over_ingame", ifc.inGame, 0);
        chk("over_pos", ifc.position, 0);
        repeat (3) @(negedge clk);
        chk("over_score", ifc.score, 1);
        chk("over_misses", ifc.misses, 2);

        ifc.pause = 1'b1;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.pause = 1'b0;
        exp_score = 0;
        exp_miss = 0;
        chk("restart_ingame", ifc.inGame, 1);
        chk("restart_score", ifc.score, 0);
        chk("restart_misses", ifc.misses, 0);
        chk("restart_over", ifc.game_over, 0);
        chk("restart_stop", ifc.stop, 1);
        gap_phase(1'b1);
        play_round(19, -1);
        gap_phase(1'b0);
        ifc.key_valid = 1'b1;
        ifc.key_code = 4'(exp_t);
        @(negedge clk);
        ifc.key_valid = 1'b0;
        chk("pre_rst_hit", ifc.hit, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        rst = 1'b0;
        exp_prev = 0;
        @(negedge clk);

        rounds = 0;
        while (rounds < 200) begin
            ifc.start = 1'b1;
            @(negedge clk);
            ifc.start = 1'b0;
            exp_score = 0;
            exp_miss = 0;
            chk("loop_start", ifc.inGame, 1);
            for (int k = 0; k < 3; k++) begin
                gap_phase(1'b0);
                play_round((rounds % 4 == 0) ? -1 : (rounds * 7) % 20, -1);
                rounds++;
            end
            chk("loop_over", ifc.game_over, 1);
            chk("loop_ingame", ifc.inGame, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mole_game_ctrl.md
# mole_game_ctrl

Game controller for the 3x3 whack-a-mole display. It sequences rounds and picks a pseudo-random target cell 1..9 for each one. It judges keypad presses against the target, keeps score, and drives `inGame`, `stop`, `hit` and `position` into the VGA driver, which renders them directly.

## Interface
Parameters:
- TICK_DIV, 50000 — clk cycles per millisecond tick.
- SHOW_MS, 800 — ms the target stays lit waiting for a press.
- FLASH_MS, 200 — ms the hit/result flash is held.
- GAP_MS, 300 — ms blank between rounds.
- ROUNDS, 20 — rounds per game (1..255).
- SEED, 8'hA5 — LFSR reset value (nonzero).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts or restarts a game from IDLE/OVER.
- pause  in  1  level; freezes the game while high.
- key_valid  in  1  one-cycle strobe, debounced keypad press.
- key_code  in  4  pressed cell, 1..9; other values never match.
- inGame  out  1  high from start accepted until OVER.
- stop  out  1  registered copy of pause while inGame, else 0.
- hit  out  1  high during FLASH after a correct press.
- position  out  4  lit cell 1..9, 0 = none.
- score  out  8  correct hits, saturates at 255.
- misses  out  8  timed-out rounds, saturates at 255.
- game_over  out  1  high in OVER.

## Operation
- Reset values: state IDLE, all outputs 0, round counter 0, LFSR = SEED, timers 0.
- Timer: prescaler 0..TICK_DIV-1 yields ms tick; ms counter cleared on every state entry; "expiry" = ms counter reaching state's limit on a tick.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Free-runs every cycle except during rst.
- States:
  - IDLE: outputs 0. `start` → GAP; clears score, misses, round; inGame=1.
  - GAP: position=0, hit=0. On expiry, compute cand = (lfsr mod 9)+1. If cand == previous target, use cand+1, with 10 wrapping to 1. Latch as target; go SHOW.
  - SHOW: position=target. If key_valid and key_code==target: score++, hit=1, go FLASH. A wrong key is ignored. On expiry without a hit: misses++, go FLASH with hit=0.
  - FLASH: position=target, hit held. On expiry: round++. If round == ROUNDS, go OVER; else go GAP.
  - OVER: inGame=0, game_over=1, position=0, score/misses held. `start` → GAP, as from IDLE, with game_over cleared.
- pause (while inGame): state, timers and prescaler frozen. Keys ignored. stop=1. Outputs otherwise held.
- Simultaneous events:
  - Correct key on the SHOW expiry cycle counts as a hit.
  - `start` while inGame is ignored.
  - `start` with pause high in IDLE/OVER is still accepted.
- rst mid-game: next cycle is IDLE with all reset values, regardless of state.

## Timing
- All outputs registered. Changes appear one cycle after the causing input edge or expiry.
- key_valid (correct) at cycle n → hit=1, score+1 at n+1.
- `start` at n → inGame=1, position=0 at n+1; first target appears GAP_MS·TICK_DIV cycles later, ±1 cycle.
- SHOW without a press lasts SHOW_MS·TICK_DIV cycles. FLASH lasts FLASH_MS·TICK_DIV cycles.
- pause at n → stop=1 at n+1; timing resumes exactly where it was frozen.
- Position is only ever 1..9 in SHOW/FLASH; consecutive targets never repeat.

## Structure
- Package `mole_pkg`:
  - state enum (IDLE, GAP, SHOW, FLASH, OVER);
  - LFSR tap mask constant;
  - POS_NONE=4'd0, POS_MAX=4'd9.
- Sub-module `ms_timer`: prescaler plus ms counter, with inputs clr, en (=!pause) and limit, and output expired.
- FSM, LFSR, target picker and counters live in the top.

## Test plan
Use TICK_DIV=4, SHOW_MS=5, FLASH_MS=2, GAP_MS=3, ROUNDS=3.
1. Reset then `start` → inGame=1 next cycle; position 0 for 12 cycles, then 1..9.
2. In SHOW, press key_code = position → hit=1, score=1 one cycle later; position held 8 cycles; then position=0.
3. No press in SHOW → after 20 cycles misses=1, hit=0; wrong key_code mid-SHOW changes nothing.
4. Play 3 rounds → game_over=1, inGame=0, position=0 after the third FLASH. `start` → score=0, misses=0, new game.
5. pause for 50 cycles mid-SHOW → stop=1, key ignored, position unchanged. Release → remaining SHOW time is exactly the pre-pause remainder.
6. Assert rst mid-FLASH → next cycle all outputs 0, state IDLE. Run 200 rounds with the ROUNDS override → no target repeats and every position is in 1..9.
